// File: rtl/seq_det_pkg.sv
// Shared types and default widths for the serial pattern detector slice.
// Provides the run-control state enum and the pattern-length width.
package seq_det_pkg;

    localparam int LEN_W       = 4;
    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_CNT_W   = 8;
    localparam int DEF_TMO_W   = 16;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        RUN,
        DONE,
        TMO
    } state_t;

endpackage

// File: rtl/seq_det_ctrl_if.sv
// Host config/strobe bus plus serial input and status outputs of seq_det_ctrl.
// master: host side (drives cfg_*, start, abort, sequence_*); slave: detector side.
interface seq_det_ctrl_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int TMO_W   = 16
);
    import seq_det_pkg::*;

    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic [CNT_W-1:0]   cfg_target;
    logic [TMO_W-1:0]   cfg_timeout;
    logic               start;
    logic               abort;
    logic               sequence_in;
    logic               sequence_valid;
    logic               busy;
    logic               detector_out;
    logic [CNT_W-1:0]   match_count;
    logic               done;
    logic               timeout;
    logic               cfg_err;

    modport master (
        output cfg_pattern, cfg_len, cfg_target, cfg_timeout,
        output start, abort, sequence_in, sequence_valid,
        input  busy, detector_out, match_count, done, timeout, cfg_err
    );

    modport slave (
        input  cfg_pattern, cfg_len, cfg_target, cfg_timeout,
        input  start, abort, sequence_in, sequence_valid,
        output busy, detector_out, match_count, done, timeout, cfg_err
    );

endinterface

// File: rtl/seq_match_core.sv
// History shift register, fill counter and masked compare against the pattern.
// Ports: clock/reset, clear, shift_en, bit_in, pattern, len; hit (comb), det_o (reg).
module seq_match_core
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               shift_en,
    input  logic               bit_in,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    output logic               hit,
    output logic               det_o
);

    localparam int MW = MAX_LEN + 1;

    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [MW-1:0]      ext;
    logic [MW-1:0]      mask;
    logic               det_q;

    // Compare uses the history including the bit being accepted now.
    always_comb begin
        ext    = {hist_q, bit_in};
        hist_d = ext[MAX_LEN-1:0];
        fill_d = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + 1'b1;
        mask   = (MW'(1) << len) - MW'(1);
        hit    = shift_en && (fill_d >= len) &&
                 (((hist_d ^ pattern) & mask[MAX_LEN-1:0]) == '0);
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            hist_q <= '0;
            fill_q <= '0;
            det_q  <= 1'b0;
        end else begin
            det_q <= hit;
            if (shift_en) begin
                hist_q <= hist_d;
                fill_q <= fill_d;
            end
        end
    end

    assign det_o = det_q;

endmodule

// File: rtl/seq_det_ctrl.sv
// Run-control wrapper: cfg latch, IDLE/ARM/RUN/DONE/TMO FSM, match counter, timer.
// Ports: clock, reset (sync, active-high), bus (seq_det_ctrl_if.slave).
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TMO_W   = DEF_TMO_W
) (
    input logic          clock,
    input logic          reset,
    seq_det_ctrl_if.slave bus
);

    state_t             state_q;
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic [CNT_W-1:0]   tgt_q;
    logic [TMO_W-1:0]   tmo_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TMO_W-1:0]   timer_q;
    logic               busy_q;
    logic               done_q;
    logic               tmo_pulse_q;
    logic               err_q;
    logic               hit;
    logic               det;
    logic               shift_en;
    logic               arm;
    logic               cfg_bad;
    logic               tmo_hit;

    always_comb begin
        arm      = (state_q == ARM);
        shift_en = (state_q == RUN) && bus.sequence_valid && !bus.abort;
        cnt_d    = cnt_q + 1'b1;
        cfg_bad  = (bus.cfg_len == '0) ||
                   (bus.cfg_len > LEN_W'(MAX_LEN)) ||
                   (bus.cfg_target == '0);
        tmo_hit  = (tmo_q != '0) && (timer_q == tmo_q - TMO_W'(1));
    end

    seq_match_core #(
        .MAX_LEN (MAX_LEN)
    ) u_core (
        .clock    (clock),
        .reset    (reset),
        .clear    (arm),
        .shift_en (shift_en),
        .bit_in   (bus.sequence_in),
        .pattern  (pat_q),
        .len      (len_q),
        .hit      (hit),
        .det_o    (det)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            pat_q       <= '0;
            len_q       <= '0;
            tgt_q       <= '0;
            tmo_q       <= '0;
            cnt_q       <= '0;
            timer_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tmo_pulse_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            tmo_pulse_q <= 1'b0;
            err_q       <= 1'b0;
            if (bus.abort) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (bus.start) begin
                            pat_q <= bus.cfg_pattern;
                            len_q <= bus.cfg_len;
                            tgt_q <= bus.cfg_target;
                            tmo_q <= bus.cfg_timeout;
                            if (cfg_bad) begin
                                err_q <= 1'b1;
                            end else begin
                                state_q <= ARM;
                                busy_q  <= 1'b1;
                            end
                        end
                    end
                    ARM: begin
                        cnt_q   <= '0;
                        timer_q <= '0;
                        state_q <= RUN;
                    end
                    RUN: begin
                        timer_q <= timer_q + 1'b1;
                        // A final match on the budget's last cycle takes DONE.
                        if (hit) cnt_q <= cnt_d;
                        if (hit && cnt_d == tgt_q) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else if (tmo_hit) begin
                            state_q     <= TMO;
                            tmo_pulse_q <= 1'b1;
                        end
                    end
                    DONE, TMO: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.busy         = busy_q;
    assign bus.detector_out = det;
    assign bus.match_count  = cnt_q;
    assign bus.done         = done_q;
    assign bus.timeout      = tmo_pulse_q;
    assign bus.cfg_err      = err_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl: reset, matching, overlap, timeout,
// config errors, abort, invalid-cycle junk, DONE-beats-timeout, mid-run reset.
module tb_seq_det_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    seq_det_ctrl_if #(.MAX_LEN(8), .CNT_W(8), .TMO_W(16)) b ();

    seq_det_ctrl #(
        .MAX_LEN (8),
        .CNT_W   (8),
        .TMO_W   (16)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (b.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input logic [7:0] obs,
                        input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic [7:0] pat, input logic [3:0] len,
                       input logic [7:0] tgt, input logic [15:0] tmo);
        b.cfg_pattern = pat;
        b.cfg_len     = len;
        b.cfg_target  = tgt;
        b.cfg_timeout = tmo;
    endtask

    // start pulse, then one more edge: the bench is left in the first RUN cycle
    task automatic go();
        b.start = 1'b1;
        tick();
        b.start = 1'b0;
        tick();
    endtask

    task automatic send(input logic v, input logic d);
        b.sequence_valid = v;
        b.sequence_in    = d;
        tick();
        b.sequence_valid = 1'b0;
        b.sequence_in    = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        b.start  = 1'b0;
        b.abort  = 1'b0;
        b.sequence_in    = 1'b0;
        b.sequence_valid = 1'b0;
        cfg(8'h0B, 4'd4, 8'd1, 16'd0);
        tick();
        tick();
        rst = 1'b0;

        chk("rst_busy", b.busy, 1'b0);
        chk("rst_det", b.detector_out, 1'b0);
        chkn("rst_cnt", b.match_count, 8'd0);
        chk("rst_done", b.done, 1'b0);
        chk("rst_tmo", b.timeout, 1'b0);
        chk("rst_err", b.cfg_err, 1'b0);

        // 1: single match, target 1; early bit offered before RUN is ignored
        cfg(8'h0B, 4'd4, 8'd1, 16'd0);
        b.start          = 1'b1;
        b.sequence_valid = 1'b1;
        b.sequence_in    = 1'b1;
        tick();
        b.start = 1'b0;
        chk("t1_busy_arm", b.busy, 1'b1);
        tick();
        b.sequence_valid = 1'b0;
        send(1, 0); send(1, 0); send(1, 1); send(1, 0); send(1, 1);
        chk("t1_no_early_det", b.detector_out, 1'b0);
        send(1, 1);
        chk("t1_det", b.detector_out, 1'b1);
        chk("t1_done", b.done, 1'b1);
        chkn("t1_cnt", b.match_count, 8'd1);
        chk("t1_busy_done", b.busy, 1'b1);
        tick();
        chk("t1_busy_drop", b.busy, 1'b0);
        chk("t1_det_off", b.detector_out, 1'b0);
        chk("t1_done_off", b.done, 1'b0);

        // 2: overlapping matches, target 2
        cfg(8'h0B, 4'd4, 8'd2, 16'd0);
        go();
        send(1, 1); send(1, 0); send(1, 1); send(1, 1);
        chk("t2_det1", b.detector_out, 1'b1);
        chk("t2_done_early", b.done, 1'b0);
        chkn("t2_cnt1", b.match_count, 8'd1);
        send(1, 0); send(1, 1);
        chk("t2_no_det", b.detector_out, 1'b0);
        send(1, 1);
        chk("t2_det2", b.detector_out, 1'b1);
        chk("t2_done", b.done, 1'b1);
        chkn("t2_cnt2", b.match_count, 8'd2);
        tick();
        chk("t2_idle", b.busy, 1'b0);

        // 3: timeout 20 cycles after RUN entry
        cfg(8'h0B, 4'd4, 8'd3, 16'd20);
        go();
        b.sequence_valid = 1'b1;
        b.sequence_in    = 1'b0;
        for (int i = 0; i < 19; i++) tick();
        chk("t3_tmo_early", b.timeout, 1'b0);
        tick();
        b.sequence_valid = 1'b0;
        chk("t3_tmo", b.timeout, 1'b1);
        chk("t3_no_done", b.done, 1'b0);
        chkn("t3_cnt", b.match_count, 8'd0);
        tick();
        chk("t3_tmo_off", b.timeout, 1'b0);
        chk("t3_idle", b.busy, 1'b0);

        // 4: rejected configurations
        cfg(8'h0B, 4'd0, 8'd1, 16'd0);
        b.start = 1'b1;
        tick();
        b.start = 1'b0;
        chk("t4_err_len0", b.cfg_err, 1'b1);
        chk("t4_busy_len0", b.busy, 1'b0);
        tick();
        chk("t4_err_off", b.cfg_err, 1'b0);
        cfg(8'h0B, 4'd9, 8'd1, 16'd0);
        b.start = 1'b1;
        tick();
        b.start = 1'b0;
        chk("t4_err_len9", b.cfg_err, 1'b1);
        chk("t4_busy_len9", b.busy, 1'b0);
        tick();
        cfg(8'h0B, 4'd4, 8'd0, 16'd0);
        b.start = 1'b1;
        tick();
        b.start = 1'b0;
        chk("t4_err_tgt0", b.cfg_err, 1'b1);
        chk("t4_busy_tgt0", b.busy, 1'b0);
        tick();

        // abort beats start
        cfg(8'h0B, 4'd4, 8'd1, 16'd0);
        b.start = 1'b1;
        b.abort = 1'b1;
        tick();
        b.start = 1'b0;
        b.abort = 1'b0;
        chk("ab_start_busy", b.busy, 1'b0);
        chk("ab_start_err", b.cfg_err, 1'b0);

        // 5: abort after one match, then restart clears count
        cfg(8'h0B, 4'd4, 8'd3, 16'd0);
        go();
        send(1, 1); send(1, 0); send(1, 1); send(1, 1);
        chkn("t5_cnt1", b.match_count, 8'd1);
        b.abort = 1'b1;
        tick();
        b.abort = 1'b0;
        chk("t5_abort_busy", b.busy, 1'b0);
        chk("t5_abort_done", b.done, 1'b0);
        chk("t5_abort_tmo", b.timeout, 1'b0);
        chkn("t5_cnt_hold", b.match_count, 8'd1);
        tick();
        chkn("t5_cnt_hold2", b.match_count, 8'd1);
        b.start = 1'b1;
        tick();
        b.start = 1'b0;
        chk("t5_rearm_busy", b.busy, 1'b1);
        tick();
        chkn("t5_cnt_clear", b.match_count, 8'd0);
        b.abort = 1'b1;
        tick();
        b.abort = 1'b0;

        // 6: junk on invalid cycles; final match on the budget's last cycle
        cfg(8'h0B, 4'd4, 8'd1, 16'd8);
        go();
        send(1, 1); send(0, 1); send(1, 0); send(0, 0);
        send(1, 1); send(0, 0); send(0, 0);
        chk("t6_no_det", b.detector_out, 1'b0);
        chk("t6_no_tmo_early", b.timeout, 1'b0);
        send(1, 1);
        chk("t6_det", b.detector_out, 1'b1);
        chk("t6_done", b.done, 1'b1);
        chk("t6_no_tmo", b.timeout, 1'b0);
        chkn("t6_cnt", b.match_count, 8'd1);
        tick();
        chk("t6_no_tmo_after", b.timeout, 1'b0);
        chk("t6_idle", b.busy, 1'b0);

        // reset mid-RUN on the edge that would have matched
        cfg(8'h0B, 4'd4, 8'd2, 16'd0);
        go();
        send(1, 1); send(1, 0); send(1, 1);
        b.sequence_valid = 1'b1;
        b.sequence_in    = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        b.sequence_valid = 1'b0;
        chk("rr_busy", b.busy, 1'b0);
        chk("rr_det", b.detector_out, 1'b0);
        chkn("rr_cnt", b.match_count, 8'd0);
        chk("rr_done", b.done, 1'b0);
        chk("rr_tmo", b.timeout, 1'b0);
        chk("rr_err", b.cfg_err, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
